lbp_host_mem: RTL and testbench

- Host-side responder for the LBP engine's memory interfaces.
- Loads an 8x8 grayscale image from an input stream and serves the engine's gray-memory reads.
- Captures the engine's LBP result writes into a 64-entry result store.
- After the engine signals finish, streams all 64 result entries out in raster order; unwritten (border) entries read as 0.

---
 rtl/lbp_host_mem.sv | 102 ++++++++++
 tb/tb_lbp_host_mem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_host_mem.sv
// Host-side responder for the LBP engine: loads an 8x8 image, serves gray reads,
// captures result writes and streams the 64-entry result store back out.
module lbp_host_mem #(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              engine_start,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_write,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W:0]   wr_count,
  output logic              done
);

  localparam int NPIX = IMG_W * IMG_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(NPIX);

  typedef enum logic [1:0] {LOAD, SERVE, DUMP, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ldIdx;
  logic [ADDR_W-1:0] r_dumpIdx;
  logic [ADDR_W:0]   r_wrCount;
  logic [NPIX-1:0]   r_valid;
  logic              r_start;
  logic [DATA_W-1:0] r_img [NPIX];
  logic [DATA_W-1:0] r_res [NPIX];
  logic              w_loadAcc;
  logic              w_resWr;
  logic              w_dumpAcc;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (in_valid && r_ldIdx == LAST_ADDR) w_next = SERVE;
      SERVE:   if (finish) w_next = DUMP;
      DUMP:    if (out_ready && r_dumpIdx == LAST_ADDR) w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == LOAD);
    out_valid = (r_state == DUMP);
    done      = (r_state == DONE);
    w_loadAcc = in_ready && in_valid;
    w_resWr   = (r_state == SERVE) && lbp_write;
    w_dumpAcc = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ldIdx   <= '0;
      r_dumpIdx <= '0;
      r_wrCount <= '0;
      r_valid   <= '0;
      r_start   <= 1'b0;
    end else begin
      r_start <= w_loadAcc && (r_ldIdx == LAST_ADDR);
      if (w_loadAcc) r_ldIdx <= r_ldIdx + ADDR_W'(1);
      if (w_dumpAcc) r_dumpIdx <= r_dumpIdx + ADDR_W'(1);
      if (w_resWr) begin
        r_valid[lbp_addr] <= 1'b1;
        if (r_wrCount != MAX_COUNT) r_wrCount <= r_wrCount + (ADDR_W + 1)'(1);
      end
    end
  end

  // Storage arrays are not reset; result entries are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_loadAcc) r_img[r_ldIdx] <= in_data;
    if (w_resWr)   r_res[lbp_addr] <= lbp_data;
  end

  assign engine_start = r_start;
  assign wr_count     = r_wrCount;
  assign gray_data    = ((r_state == SERVE) && gray_req) ? r_img[gray_addr] : '0;
  assign out_data     = r_valid[r_dumpIdx] ? r_res[r_dumpIdx] : '0;
  assign out_last     = out_valid && (r_dumpIdx == LAST_ADDR);

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem with a per-cycle behavioural model and
// literal spot checks of the dump contents.
module tb_lbp_host_mem;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       engine_start;
  logic       gray_req;
  logic [5:0] gray_addr;
  logic [7:0] gray_data;
  logic       lbp_write;
  logic [5:0] lbp_addr;
  logic [7:0] lbp_data;
  logic       finish;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [6:0] wr_count;
  logic       done;

  lbp_host_mem dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .engine_start(engine_start),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_write(lbp_write), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .wr_count(wr_count), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int asserts  = 0;
  int failures = 0;

  typedef enum {M_LOAD, M_SERVE, M_DUMP, M_DONE} phase_t;
  phase_t mPhase = M_LOAD;
  int     mLd    = 0;
  int     mCnt   = 0;
  int     mDump  = 0;
  bit     mStart = 1'b0;
  int     mImg [64];
  int     mRes [64];

  int got [$];
  int lastCount = 0;
  int lastAt    = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Outputs are compared on the falling edge, then the model absorbs the
  // inputs that the DUT will sample on the following rising edge.
  always @(negedge clk) begin
    checkOutput("in_ready", 32'(in_ready), 32'(mPhase == M_LOAD));
    checkOutput("engine_start", 32'(engine_start), 32'(mStart));
    checkOutput("out_valid", 32'(out_valid), 32'(mPhase == M_DUMP));
    checkOutput("done", 32'(done), 32'(mPhase == M_DONE));
    checkOutput("wr_count", 32'(wr_count), 32'(mCnt));
    checkOutput("gray_data", 32'(gray_data),
                (mPhase == M_SERVE && gray_req) ? 32'(mImg[gray_addr]) : 32'd0);
    if (mPhase == M_DUMP) begin
      checkOutput("out_data", 32'(out_data), 32'(mRes[mDump]));
      checkOutput("out_last", 32'(out_last), 32'(mDump == 63));
    end
    if (reset && out_valid && out_ready) begin
      if (out_last) begin
        lastCount++;
        lastAt = got.size();
      end
      got.push_back(int'(out_data));
    end

    if (!reset) begin
      mPhase = M_LOAD; mLd = 0; mCnt = 0; mDump = 0; mStart = 1'b0;
      for (int i = 0; i < 64; i++) mRes[i] = 0;
    end else begin
      mStart = 1'b0;
      case (mPhase)
        M_LOAD: if (in_valid) begin
          mImg[mLd] = int'(in_data);
          if (mLd == 63) begin
            mLd = 0; mPhase = M_SERVE; mStart = 1'b1;
          end else mLd++;
        end
        M_SERVE: begin
          if (lbp_write) begin
            mRes[lbp_addr] = int'(lbp_data);
            if (mCnt < 64) mCnt++;
          end
          if (finish) mPhase = M_DUMP;
        end
        M_DUMP: if (out_ready) begin
          if (mDump == 63) mPhase = M_DONE;
          else mDump++;
        end
        default: mPhase = M_DONE;
      endcase
    end
  end

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
  endtask

  task automatic loadImage(input int mul, input int add);
    int starts;
    starts = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 8'((i * mul + add) & 8'hFF);
      applyStimulus(1);
      if (engine_start) starts++;
      if (i == 62) checkOutput("ready_before_last", 32'(in_ready), 32'd1);
    end
    checkOutput("ready_after_64", 32'(in_ready), 32'd0);
    in_data = 8'hEE;
    applyStimulus(1);
    in_valid = 1'b0;
    if (engine_start) starts++;
    checkOutput("start_pulses", 32'(starts), 32'd1);
  endtask

  task automatic runDump(input logic [3:0] pat);
    int cyc;
    got.delete();
    lastCount = 0;
    lastAt = -1;
    cyc = 0;
    while (!done && cyc < 600) begin
      out_ready = pat[cyc % 4];
      applyStimulus(1);
      cyc++;
    end
    out_ready = 1'b0;
    if (!done) checkOutput("dump_timeout", 32'd0, 32'd1);
    checkOutput("dump_count", 32'(got.size()), 32'd64);
    checkOutput("last_count", 32'(lastCount), 32'd1);
    checkOutput("last_index", 32'(lastAt), 32'd63);
  endtask

  initial begin
    int nonzero;
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    gray_req = 1'b0; gray_addr = '0;
    lbp_write = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; out_ready = 1'b0;
    applyStimulus(2);
    reset = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    lbp_write = 1'b1; lbp_addr = 6'd5; lbp_data = 8'h99; finish = 1'b1;
    applyStimulus(3);
    lbp_write = 1'b0; finish = 1'b0;
    checkOutput("load_ignore_count", 32'(wr_count), 32'd0);
    checkOutput("load_ignore_state", 32'(in_ready), 32'd1);

    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = 8'(200 + i);
      applyStimulus(1);
    end
    in_valid = 1'b0;
    doReset();
    checkOutput("midreset_ready", 32'(in_ready), 32'd1);

    loadImage(1, 0);

    gray_req = 1'b1; gray_addr = 6'd27;
    #1 checkOutput("gray_27", 32'(gray_data), 32'd27);
    applyStimulus(1);
    gray_req = 1'b0;
    #1 checkOutput("gray_noreq", 32'(gray_data), 32'd0);
    applyStimulus(1);
    gray_req = 1'b1; gray_addr = 6'd63;
    #1 checkOutput("gray_63", 32'(gray_data), 32'd63);
    applyStimulus(1);
    gray_req = 1'b0;

    lbp_write = 1'b1;
    lbp_addr = 6'd9;  lbp_data = 8'hA5; applyStimulus(1);
    lbp_addr = 6'd54; lbp_data = 8'h3C; applyStimulus(1);
    lbp_addr = 6'd9;  lbp_data = 8'h11; applyStimulus(1);
    lbp_write = 1'b0;
    checkOutput("wr_count_3", 32'(wr_count), 32'd3);
    finish = 1'b1;
    applyStimulus(1);
    finish = 1'b0;
    checkOutput("dump_entered", 32'(out_valid), 32'd1);

    runDump(4'b1001);
    if (got.size() == 64) begin
      checkOutput("entry9", 32'(got[9]), 32'h11);
      checkOutput("entry54", 32'(got[54]), 32'h3C);
      checkOutput("entry0", 32'(got[0]), 32'd0);
      nonzero = 0;
      for (int i = 0; i < 64; i++) if (got[i] != 0) nonzero++;
      checkOutput("nonzero_entries", 32'(nonzero), 32'd2);
    end
    checkOutput("done_after_dump", 32'(done), 32'd1);
    finish = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    applyStimulus(3);
    finish = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("done_sticky", 32'(done), 32'd1);

    doReset();
    loadImage(5, 3);
    gray_req = 1'b1; gray_addr = 6'd27;
    #1 checkOutput("gray_27_run2", 32'(gray_data), 32'd138);
    gray_req = 1'b0;
    lbp_write = 1'b1;
    for (int i = 0; i < 66; i++) begin
      lbp_addr = 6'(i % 64);
      lbp_data = 8'(i);
      applyStimulus(1);
    end
    checkOutput("wr_count_sat", 32'(wr_count), 32'd64);
    lbp_addr = 6'd63; lbp_data = 8'h77; finish = 1'b1;
    applyStimulus(1);
    finish = 1'b0;
    lbp_addr = 6'd0; lbp_data = 8'hAA;
    gray_req = 1'b1;
    runDump(4'b1111);
    lbp_write = 1'b0; gray_req = 1'b0;
    checkOutput("wr_count_final", 32'(wr_count), 32'd64);
    if (got.size() == 64) begin
      checkOutput("entry63_same_cycle", 32'(got[63]), 32'h77);
      checkOutput("entry0_overwrite", 32'(got[0]), 32'd64);
      checkOutput("entry2_run2", 32'(got[2]), 32'd2);
    end

    applyStimulus(2);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
